// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: steps an NCO tuning word from start toward stop,
// holding each word for a number of accepted beats, with one-shot or continuous passes.
module nco_sweep_ctrl #(
    parameter int unsigned FTW_WIDTH   = 32,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FTW_WIDTH-1:0]   cfg_ftw_start,
    input  logic [FTW_WIDTH-1:0]   cfg_ftw_step,
    input  logic [FTW_WIDTH-1:0]   cfg_ftw_stop,
    input  logic                   cfg_dir,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_continuous,
    output logic [FTW_WIDTH-1:0]   m_axis_ftw_tdata,
    output logic                   m_axis_ftw_tvalid,
    input  logic                   m_axis_ftw_tready,
    output logic                   busy,
    output logic                   done,
    output logic [DWELL_WIDTH-1:0] step_idx
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [FTW_WIDTH-1:0]   start_q, start_d;
    logic [FTW_WIDTH-1:0]   step_q, step_d;
    logic [FTW_WIDTH-1:0]   stop_q, stop_d;
    logic                   dir_q, dir_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic                   cont_q, cont_d;
    logic [FTW_WIDTH-1:0]   ftw_q, ftw_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [DWELL_WIDTH-1:0] idx_q, idx_d;

    logic [DWELL_WIDTH-1:0] eff_dwell;
    logic [DWELL_WIDTH-1:0] last_cnt;
    logic [FTW_WIDTH:0]     next_w;
    logic                   past_limit;

    // A programmed dwell of zero behaves as a dwell of one.
    assign eff_dwell = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
    assign last_cnt  = eff_dwell - DWELL_WIDTH'(1);

    // Extra MSB captures carry (up) or borrow (down).
    assign next_w = dir_q ? ({1'b0, ftw_q} - {1'b0, step_q})
                          : ({1'b0, ftw_q} + {1'b0, step_q});
    assign past_limit = next_w[FTW_WIDTH] |
                        (dir_q ? (next_w[FTW_WIDTH-1:0] < stop_q)
                               : (next_w[FTW_WIDTH-1:0] > stop_q));

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        step_d  = step_q;
        stop_d  = stop_q;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        ftw_d   = ftw_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    start_d = cfg_ftw_start;
                    step_d  = cfg_ftw_step;
                    stop_d  = cfg_ftw_stop;
                    dir_d   = cfg_dir;
                    dwell_d = cfg_dwell;
                    cont_d  = cfg_continuous;
                    ftw_d   = cfg_ftw_start;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (m_axis_ftw_tready) begin
                    if (cnt_q == last_cnt) begin
                        cnt_d = '0;
                        // Zero step parks on the start word until abort or reset.
                        if (step_q != '0) begin
                            if (past_limit) begin
                                idx_d = '0;
                                if (cont_q) begin
                                    ftw_d = start_q;
                                end else begin
                                    state_d = StDone;
                                end
                            end else begin
                                ftw_d = next_w[FTW_WIDTH-1:0];
                                idx_d = (&idx_q) ? idx_q : idx_q + DWELL_WIDTH'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_WIDTH'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q <= StIdle;
            start_q <= '0;
            step_q  <= '0;
            stop_q  <= '0;
            dir_q   <= 1'b0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            ftw_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            step_q  <= step_d;
            stop_q  <= stop_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            ftw_q   <= ftw_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign m_axis_ftw_tvalid = (state_q == StRun);
    assign m_axis_ftw_tdata  = (state_q == StRun) ? ftw_q : '0;
    assign busy              = (state_q == StRun);
    assign done              = (state_q == StDone);
    assign step_idx          = idx_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed-vector bench for nco_sweep_ctrl with hand-computed expected words.
module tb_nco_sweep_ctrl;

    logic        aclk = 1'b0;
    logic        arst;
    logic        start;
    logic        abort;
    logic [31:0] cfg_ftw_start;
    logic [31:0] cfg_ftw_step;
    logic [31:0] cfg_ftw_stop;
    logic        cfg_dir;
    logic [15:0] cfg_dwell;
    logic        cfg_continuous;
    logic [31:0] m_axis_ftw_tdata;
    logic        m_axis_ftw_tvalid;
    logic        m_axis_ftw_tready;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_up   [8] = '{100, 100, 150, 150, 200, 200, 250, 250};
    logic [31:0] exp_dn   [4] = '{1000, 700, 400, 100};
    logic [31:0] exp_cont [7] = '{10, 20, 30, 10, 20, 30, 10};
    logic        bp_pat   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    nco_sweep_ctrl #(
        .FTW_WIDTH   (32),
        .DWELL_WIDTH (16)
    ) dut (
        .aclk              (aclk),
        .arst              (arst),
        .start             (start),
        .abort             (abort),
        .cfg_ftw_start     (cfg_ftw_start),
        .cfg_ftw_step      (cfg_ftw_step),
        .cfg_ftw_stop      (cfg_ftw_stop),
        .cfg_dir           (cfg_dir),
        .cfg_dwell         (cfg_dwell),
        .cfg_continuous    (cfg_continuous),
        .m_axis_ftw_tdata  (m_axis_ftw_tdata),
        .m_axis_ftw_tvalid (m_axis_ftw_tvalid),
        .m_axis_ftw_tready (m_axis_ftw_tready),
        .busy              (busy),
        .done              (done),
        .step_idx          (step_idx)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; inputs set afterwards hold until the next edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] st, input logic [31:0] sp,
                          input logic d, input logic [15:0] dw, input logic c);
        cfg_ftw_start  = s;
        cfg_ftw_step   = st;
        cfg_ftw_stop   = sp;
        cfg_dir        = d;
        cfg_dwell      = dw;
        cfg_continuous = c;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".tvalid"}, 64'(m_axis_ftw_tvalid), 64'd0);
        check({tag, ".tdata"},  64'(m_axis_ftw_tdata),  64'd0);
        check({tag, ".busy"},   64'(busy),              64'd0);
        check({tag, ".done"},   64'(done),              64'd0);
    endtask

    initial begin
        arst = 1'b1; start = 1'b0; abort = 1'b0; m_axis_ftw_tready = 1'b1;
        cfg_ftw_start = 32'd7; cfg_ftw_step = 32'd1; cfg_ftw_stop = 32'd9;
        cfg_dir = 1'b0; cfg_dwell = 16'd1; cfg_continuous = 1'b0;
        tick();
        tick();
        check_idle("reset");
        check("reset.idx", 64'(step_idx), 64'd0);

        // Up sweep with dwell 2; start accepted on the first cycle out of reset
        arst = 1'b0;
        launch(32'd100, 32'd50, 32'd250, 1'b0, 16'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("up.tdata[%0d]", i), 64'(m_axis_ftw_tdata), 64'(exp_up[i]));
            check($sformatf("up.tvalid[%0d]", i), 64'(m_axis_ftw_tvalid), 64'd1);
            check($sformatf("up.idx[%0d]", i), 64'(step_idx), 64'(i / 2));
            tick();
        end
        check("up.done", 64'(done), 64'd1);
        check("up.done_tvalid", 64'(m_axis_ftw_tvalid), 64'd0);
        check("up.done_busy", 64'(busy), 64'd0);
        check("up.done_tdata", 64'(m_axis_ftw_tdata), 64'd0);
        tick();
        check_idle("up.after");

        // Down sweep ending on borrow
        launch(32'd1000, 32'd300, 32'd0, 1'b1, 16'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dn.tdata[%0d]", i), 64'(m_axis_ftw_tdata), 64'(exp_dn[i]));
            check($sformatf("dn.idx[%0d]", i), 64'(step_idx), 64'(i));
            tick();
        end
        check("dn.done", 64'(done), 64'd1);
        tick();
        check_idle("dn.after");

        // Backpressure: third accepted beat lands on the fifth cycle
        launch(32'd500, 32'd5, 32'd1000, 1'b0, 16'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            m_axis_ftw_tready = bp_pat[i];
            check($sformatf("bp.hold[%0d]", i), 64'(m_axis_ftw_tdata), 64'd500);
            tick();
        end
        m_axis_ftw_tready = 1'b1;
        check("bp.next", 64'(m_axis_ftw_tdata), 64'd505);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("bp.abort");

        // Continuous wrap, then abort with no done
        launch(32'd10, 32'd10, 32'd30, 1'b0, 16'd1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("cont.tdata[%0d]", i), 64'(m_axis_ftw_tdata), 64'(exp_cont[i]));
            check($sformatf("cont.done[%0d]", i), 64'(done), 64'd0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("cont.abort");
        tick();
        check("cont.no_done", 64'(done), 64'd0);

        // Carry out of the top word
        launch(32'hFFFF_FF00, 32'h200, 32'hFFFF_FFFF, 1'b0, 16'd1, 1'b0);
        check("ovf.tdata", 64'(m_axis_ftw_tdata), 64'hFFFF_FF00);
        tick();
        check("ovf.done", 64'(done), 64'd1);
        tick();

        // Start word already past stop is still emitted once
        launch(32'd300, 32'd10, 32'd200, 1'b0, 16'd1, 1'b0);
        check("past.tdata", 64'(m_axis_ftw_tdata), 64'd300);
        tick();
        check("past.done", 64'(done), 64'd1);
        tick();

        // Abort together with start in idle keeps the FSM idle
        abort = 1'b1;
        launch(32'd55, 32'd1, 32'd60, 1'b0, 16'd1, 1'b0);
        abort = 1'b0;
        check("abst.busy", 64'(busy), 64'd0);
        check("abst.tvalid", 64'(m_axis_ftw_tvalid), 64'd0);

        // Zero step parks on the start word
        launch(32'd5, 32'd0, 32'd3, 1'b0, 16'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("zs.tdata[%0d]", i), 64'(m_axis_ftw_tdata), 64'd5);
            check($sformatf("zs.done[%0d]", i), 64'(done), 64'd0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("zs.abort");

        // Mid-sweep cfg changes and a stray start are ignored; reset mid-sweep clears all
        launch(32'd100, 32'd50, 32'd1000, 1'b0, 16'd1, 1'b0);
        check("cfg.w0", 64'(m_axis_ftw_tdata), 64'd100);
        cfg_ftw_step  = 32'd7;
        cfg_ftw_start = 32'd9;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        check("cfg.w1", 64'(m_axis_ftw_tdata), 64'd150);
        tick();
        check("cfg.w2", 64'(m_axis_ftw_tdata), 64'd200);
        check("cfg.idx", 64'(step_idx), 64'd2);
        arst = 1'b1;
        tick();
        arst = 1'b0;
        check_idle("arst");
        check("arst.idx", 64'(step_idx), 64'd0);

        // Fresh sweep after reset, dwell 0 behaves as 1
        launch(32'd40, 32'd1, 32'd41, 1'b0, 16'd0, 1'b0);
        check("new.w0", 64'(m_axis_ftw_tdata), 64'd40);
        tick();
        check("new.w1", 64'(m_axis_ftw_tdata), 64'd41);
        check("new.idx", 64'(step_idx), 64'd1);
        tick();
        check("new.done", 64'(done), 64'd1);
        tick();
        check_idle("new.after");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter FTW_WIDTH, default 32: tuning-word width, matching the NCO frequency input.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16: width of the dwell count and step index.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port arst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle sweep launch request.
REQ-006 SHALL have port abort, input, 1 bit: single-cycle sweep cancel request.
REQ-007 SHALL have ports cfg_ftw_start, cfg_ftw_step and cfg_ftw_stop, input, FTW_WIDTH each, unsigned: first tuning word, step magnitude, limit.
REQ-008 SHALL have port cfg_dir, input, 1 bit: 0 = sweep up, 1 = sweep down.
REQ-009 SHALL have port cfg_dwell, input, DWELL_WIDTH: accepted beats per tuning word.
REQ-010 SHALL have port cfg_continuous, input, 1 bit: 1 = restart from start at the limit.
REQ-011 SHALL have port m_axis_ftw_tdata, output, FTW_WIDTH: current tuning word to the NCO.
REQ-012 SHALL have port m_axis_ftw_tvalid, output, 1 bit: tuning word active.
REQ-013 SHALL have port m_axis_ftw_tready, input, 1 bit: the NCO accepted a beat (one sample).
REQ-014 SHALL have port busy, output, 1 bit: high in RUN.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at normal sweep completion.
REQ-016 SHALL have port step_idx, output, DWELL_WIDTH: index of the current tuning word within the current pass.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 In IDLE, start=1 and abort=0 SHALL latch all cfg_* into shadow registers and enter RUN; m_axis_ftw_tdata=cfg_ftw_start, tvalid=1 and step_idx=0 SHALL appear the next cycle.
REQ-019 cfg_* changes outside the IDLE start cycle SHALL have no effect on a sweep in progress.
REQ-020 In RUN, tvalid SHALL be 1 and tdata SHALL be held stable between step updates.
REQ-021 The dwell counter SHALL count only cycles with tvalid and tready both high.
REQ-022 A shadow dwell of 0 SHALL be treated as 1.
REQ-023 After exactly D accepted beats on one word (D = effective dwell), the next word SHALL be visible the following cycle and the dwell counter SHALL clear.
REQ-024 The next word SHALL be cur+step (up) or cur-step (down), computed FTW_WIDTH+1 bits wide.
REQ-025 A step SHALL be "past limit" when, for up, the carry is set or the result is greater than stop; for down, the borrow is set or the result is less than stop.
REQ-026 On a past-limit step with continuous=1, the word SHALL reload to the shadow start and step_idx SHALL return to 0.
REQ-027 On a past-limit step with continuous=0, the FSM SHALL enter DONE.
REQ-028 Otherwise step_idx SHALL increment, saturating at all-ones.
REQ-029 A word exactly equal to stop SHALL be emitted with its full dwell.
REQ-030 The start word SHALL always be emitted once, even if it is already past stop.
REQ-031 A shadow step of 0 SHALL hold the start word indefinitely: no done, exit only via abort or reset.
REQ-032 DONE SHALL last one cycle with done=1, tvalid=0, tdata=0 and busy=0, then go to IDLE.
REQ-033 In IDLE, tvalid=0, tdata=0, busy=0 and done=0.
REQ-034 abort=1 in RUN SHALL make the next cycle IDLE with tvalid=0 and tdata=0, and SHALL NOT pulse done.
REQ-035 abort=1 together with start=1 in IDLE SHALL win: the FSM stays in IDLE.
REQ-036 start SHALL be ignored in RUN and DONE.
REQ-037 abort SHALL be ignored in DONE.

Reset
REQ-038 arst=1 SHALL, at the next aclk edge and from any state including mid-sweep, set IDLE, tvalid=0, tdata=0, busy=0, done=0, step_idx=0, dwell counter=0 and clear the shadow registers.
REQ-039 arst SHALL take priority over start and abort.
REQ-040 The first start is accepted on the first cycle with arst=0.

Verification
REQ-041 Up sweep, start=100, step=50, stop=250, dwell=2, tready=1 -> tdata 100,100,150,150,200,200,250,250; then done=1 for 1 cycle; then tvalid=0, tdata=0.
REQ-042 Down sweep, start=1000, step=300, stop=0, dwell=1 -> tdata 1000,700,400,100; then done (100-300 borrows); step_idx 0,1,2,3.
REQ-043 Backpressure, dwell=3, tready pattern 1,0,1,0,1 -> word changes only in the cycle after the 5th cycle (3rd accepted beat).
REQ-044 Continuous, start=10, step=10, stop=30, dwell=1 -> tdata 10,20,30,10,20,...; abort -> next cycle tvalid=0, tdata=0, done never asserted.
REQ-045 Overflow, up, start=0xFFFFFF00, step=0x200, stop=0xFFFFFFFF, dwell=1 -> one word 0xFFFFFF00, then done.
REQ-046 Changing cfg_ftw_step mid-sweep has no effect on the running sweep; arst mid-sweep -> all outputs 0 next cycle; a subsequent start -> clean new sweep.
